// File: rtl/bridge_pkg.sv
// Shared types for the UART bridge host-side command encoder: instruction codes,
// encoder states and the 4-byte command header layout.
`timescale 1ns/1ps
package bridge_pkg;

  typedef enum logic [1:0] {
    INSTR_READ  = 2'b01,
    INSTR_WRITE = 2'b10
  } instr_e;

  localparam int HDR_BYTES = 4;

  // Element [0] is the first byte on the line.
  typedef logic [HDR_BYTES-1:0][7:0] hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_DATA_TX,
    ST_DONE
  } enc_state_e;

  function automatic hdr_t pack_hdr(input logic [1:0]  instr,
                                    input logic [1:0]  sel,
                                    input logic [11:0] addr,
                                    input logic [11:0] burst);
    hdr_t h;
    h[0] = {instr, sel, addr[11:8]};
    h[1] = addr[7:0];
    h[2] = {4'b0000, burst[11:8]};
    h[3] = burst[7:0];
    return h;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. A start request during the last stop-bit cycle
// chains the next byte with no idle gap.
`timescale 1ns/1ps
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done
);

  localparam int             TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);

  logic          active_q, active_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    idx_q, idx_d;
  logic [9:0]    frm_q, frm_d;
  logic          tx_q, tx_d;

  assign done = active_q && (idx_q == 4'd9) && (tmr_q == T_LAST);
  assign tx   = tx_q;

  always_comb begin
    active_d = active_q;
    tmr_d    = tmr_q;
    idx_d    = idx_q;
    frm_d    = frm_q;
    tx_d     = tx_q;
    if (start && (!active_q || done)) begin
      active_d = 1'b1;
      tmr_d    = '0;
      idx_d    = 4'd0;
      frm_d    = {1'b1, byte_in, 1'b0};
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (tmr_q == T_LAST) begin
        tmr_d = '0;
        if (idx_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
          tx_d  = frm_q[idx_d];
        end
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      tmr_q    <= '0;
      idx_q    <= 4'd0;
      frm_q    <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      frm_q    <= frm_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/uart_cmd_encoder.sv
// Host-side UART bridge command encoder: takes one bus command plus write bytes and
// sequences header and data bytes onto the serial line through uart_tx_byte.
`timescale 1ns/1ps
import bridge_pkg::*;

module uart_cmd_encoder #(
  parameter int SLAVE_LEN    = 2,
  parameter int ADDR_LEN     = 12,
  parameter int DATA_LEN     = 8,
  parameter int BURST_LEN    = 12,
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_instruction,
  input  logic [SLAVE_LEN-1:0] cmd_slave_select,
  input  logic [ADDR_LEN-1:0]  cmd_address,
  input  logic [BURST_LEN-1:0] cmd_burst_num,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATA_LEN-1:0]  wdata,
  output logic                 tx_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cmd_err
);

  if (SLAVE_LEN > 2 || ADDR_LEN > 12 || BURST_LEN > 12 || DATA_LEN != 8 ||
      CLKS_PER_BIT < 2) begin : g_param_err
    $error("uart_cmd_encoder: unsupported parameter set");
  end

  enc_state_e           state_q, state_d;
  hdr_t                 hdr_q, hdr_d, hdr_in;
  logic [1:0]           hdr_idx_q, hdr_idx_d;
  logic [BURST_LEN-1:0] beat_q, beat_d;
  logic                 is_wr_q, is_wr_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 wdata_ready_q, wdata_ready_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 cmd_err_q, cmd_err_d;

  logic [1:0]  sel_ext;
  logic [11:0] addr_ext, burst_ext;
  logic        cmd_legal, tx_start, tx_done;
  logic [7:0]  tx_byte;

  always_comb begin
    sel_ext                      = '0;
    addr_ext                     = '0;
    burst_ext                    = '0;
    sel_ext[SLAVE_LEN-1:0]       = cmd_slave_select;
    addr_ext[ADDR_LEN-1:0]       = cmd_address;
    burst_ext[BURST_LEN-1:0]     = cmd_burst_num;
    hdr_in    = pack_hdr(cmd_instruction, sel_ext, addr_ext, burst_ext);
    // A write with nothing to send is meaningless; a zero-beat read is fine.
    cmd_legal = (cmd_instruction == INSTR_READ) ||
                ((cmd_instruction == INSTR_WRITE) && (cmd_burst_num != '0));
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    hdr_idx_d = hdr_idx_q;
    beat_d    = beat_q;
    is_wr_d   = is_wr_q;
    cmd_err_d = 1'b0;
    tx_start  = 1'b0;
    tx_byte   = hdr_q[hdr_idx_q];
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_legal) begin
            state_d   = ST_HDR;
            hdr_d     = hdr_in;
            hdr_idx_d = 2'd0;
            beat_d    = cmd_burst_num;
            is_wr_d   = (cmd_instruction == INSTR_WRITE);
            tx_start  = 1'b1;
            tx_byte   = hdr_in[0];
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (tx_done) begin
          if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
            state_d = is_wr_q ? ST_FETCH : ST_DONE;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
            tx_start  = 1'b1;
            tx_byte   = hdr_q[hdr_idx_d];
          end
        end
      end
      ST_FETCH: begin
        if (wdata_valid && wdata_ready_q) begin
          state_d  = ST_DATA_TX;
          beat_d   = beat_q - BURST_LEN'(1);
          tx_start = 1'b1;
          tx_byte  = wdata;
        end
      end
      ST_DATA_TX: begin
        if (tx_done) state_d = (beat_q == '0) ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    cmd_ready_d   = (state_d == ST_IDLE);
    wdata_ready_d = (state_d == ST_FETCH);
    busy_d        = (state_d == ST_HDR) || (state_d == ST_FETCH) || (state_d == ST_DATA_TX);
    frame_done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      hdr_q         <= '0;
      hdr_idx_q     <= 2'd0;
      beat_q        <= '0;
      is_wr_q       <= 1'b0;
      cmd_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      hdr_idx_q     <= hdr_idx_d;
      beat_q        <= beat_d;
      is_wr_q       <= is_wr_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk     (clk),
    .rst_n   (reset),
    .start   (tx_start),
    .byte_in (tx_byte),
    .tx      (tx_data),
    .done    (tx_done)
  );

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign cmd_err     = cmd_err_q;

endmodule
